// File: rtl/tabuleiro_pkg.sv
// Shared constants, piece codes, FSM states and piece-length lookup for the board checker.
package tabuleiro_pkg;

    localparam int unsigned LADO      = 8;
    localparam int unsigned COORD_W   = 3;
    localparam int unsigned MAX_PECAS = 11;
    localparam int unsigned TIPO_W    = 3;
    localparam int unsigned K_W       = 3;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned CELULAS   = LADO * LADO;
    localparam int unsigned IDX_W     = 2 * COORD_W;

    localparam logic [TIPO_W-1:0] SUBMARINO    = 3'd1;
    localparam logic [TIPO_W-1:0] CRUZADOR     = 3'd2;
    localparam logic [TIPO_W-1:0] HIDROAVIAO   = 3'd3;
    localparam logic [TIPO_W-1:0] ENCOURACADO  = 3'd4;
    localparam logic [TIPO_W-1:0] PORTA_AVIOES = 3'd5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECA  = 2'd1,
        RESULT = 2'd2,
        GRAVA  = 2'd3
    } estado_t;

    // Number of cells of a piece; zero flags an invalid piece code.
    function automatic logic [K_W-1:0] comprimento(input logic [TIPO_W-1:0] t);
        case (t)
            SUBMARINO:    comprimento = K_W'(1);
            CRUZADOR:     comprimento = K_W'(2);
            HIDROAVIAO:   comprimento = K_W'(3);
            ENCOURACADO:  comprimento = K_W'(4);
            PORTA_AVIOES: comprimento = K_W'(5);
            default:      comprimento = '0;
        endcase
    endfunction

endpackage

// File: rtl/gera_celula.sv
// Maps (piece, anchor, direction, orientation, cell index k) to a board cell and an out-of-board flag.
module gera_celula
    import tabuleiro_pkg::*;
(
    input  logic [TIPO_W-1:0]  tipo,
    input  logic [COORD_W-1:0] x1,
    input  logic [COORD_W-1:0] y1,
    input  logic               direcao,
    input  logic               orientacao,
    input  logic [K_W-1:0]     k,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic               fora
);

    localparam int unsigned S_W = COORD_W + 1;

    logic signed [S_W-1:0] base_main;
    logic signed [S_W-1:0] base_cross;
    logic signed [S_W-1:0] desl_main;
    logic signed [S_W-1:0] desl_cross;
    logic signed [S_W-1:0] pos_main;
    logic signed [S_W-1:0] pos_cross;

    // Signed cell arithmetic; sums past LADO-1 wrap into the negative range, so the sign bit alone marks out of board.
    always_comb begin
        base_main  = $signed({1'b0, (direcao ? y1 : x1)});
        base_cross = $signed({1'b0, (direcao ? x1 : y1)});
        desl_main  = orientacao ? -$signed(S_W'(k)) : $signed(S_W'(k));
        desl_cross = (tipo == HIDROAVIAO && k == K_W'(1)) ? S_W'(1) : '0;
        pos_main   = base_main + desl_main;
        pos_cross  = base_cross + desl_cross;
        fora       = pos_main[S_W-1] | pos_cross[S_W-1];
        cx         = direcao ? pos_cross[COORD_W-1:0] : pos_main[COORD_W-1:0];
        cy         = direcao ? pos_main[COORD_W-1:0]  : pos_cross[COORD_W-1:0];
    end

endmodule

// File: rtl/tabuleiro_conflito.sv
// Per-player occupancy store with cell-by-cell placement conflict check and commit.
module tabuleiro_conflito
    import tabuleiro_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               valida,
    input  logic               armazena,
    input  logic [TIPO_W-1:0]  tipo,
    input  logic               jogador,
    input  logic [COORD_W-1:0] X1,
    input  logic [COORD_W-1:0] Y1,
    input  logic               direcao,
    input  logic               orientacao,
    input  logic               cons_jogador,
    input  logic [COORD_W-1:0] cons_x,
    input  logic [COORD_W-1:0] cons_y,
    output logic               ocupado,
    output logic               conflito,
    output logic               checado,
    output logic               gravado,
    output logic               ocupada,
    output logic [CNT_W-1:0]   pecas_j0,
    output logic [CNT_W-1:0]   pecas_j1,
    output logic [1:0]         completo
);

    estado_t                  estado;
    logic [TIPO_W-1:0]        tipo_r;
    logic                     jog_r;
    logic [COORD_W-1:0]       x_r;
    logic [COORD_W-1:0]       y_r;
    logic                     dir_r;
    logic                     ori_r;
    logic [K_W-1:0]           k;
    logic                     pode_gravar;
    logic [1:0][CELULAS-1:0]  mapa;

    logic [COORD_W-1:0]       cx;
    logic [COORD_W-1:0]       cy;
    logic                     fora;
    logic [IDX_W-1:0]         idx;
    logic [K_W-1:0]           len;
    logic [CNT_W-1:0]         cnt_sel;

    gera_celula u_celula (
        .tipo       (tipo_r),
        .x1         (x_r),
        .y1         (y_r),
        .direcao    (dir_r),
        .orientacao (ori_r),
        .k          (k),
        .cx         (cx),
        .cy         (cy),
        .fora       (fora)
    );

    assign idx     = {cy, cx};
    assign len     = comprimento(tipo_r);
    assign cnt_sel = jog_r ? pecas_j1 : pecas_j0;
    assign ocupado = mapa[cons_jogador][{cons_y, cons_x}];

    // Check/commit FSM with registered status pulses, counters and maps.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado      <= IDLE;
            tipo_r      <= '0;
            jog_r       <= 1'b0;
            x_r         <= '0;
            y_r         <= '0;
            dir_r       <= 1'b0;
            ori_r       <= 1'b0;
            k           <= '0;
            pode_gravar <= 1'b0;
            mapa        <= '0;
            conflito    <= 1'b0;
            checado     <= 1'b0;
            gravado     <= 1'b0;
            ocupada     <= 1'b0;
            pecas_j0    <= '0;
            pecas_j1    <= '0;
            completo    <= '0;
        end else begin
            checado <= 1'b0;
            gravado <= 1'b0;
            case (estado)
                IDLE: begin
                    if (valida) begin
                        tipo_r      <= tipo;
                        jog_r       <= jogador;
                        x_r         <= X1;
                        y_r         <= Y1;
                        dir_r       <= direcao;
                        ori_r       <= orientacao;
                        k           <= '0;
                        pode_gravar <= 1'b0;
                        ocupada     <= 1'b1;
                        if (comprimento(tipo) == '0) begin
                            conflito <= 1'b1;
                            estado   <= RESULT;
                        end else begin
                            conflito <= 1'b0;
                            estado   <= CHECA;
                        end
                    end else if (armazena && pode_gravar && cnt_sel < CNT_W'(MAX_PECAS)) begin
                        k       <= '0;
                        ocupada <= 1'b1;
                        estado  <= GRAVA;
                    end
                end
                CHECA: begin
                    if (fora || mapa[jog_r][idx]) begin
                        conflito <= 1'b1;
                        estado   <= RESULT;
                    end else if (k == len - K_W'(1)) begin
                        conflito <= 1'b0;
                        estado   <= RESULT;
                    end else begin
                        k <= k + K_W'(1);
                    end
                end
                RESULT: begin
                    checado     <= 1'b1;
                    pode_gravar <= !conflito;
                    ocupada     <= 1'b0;
                    estado      <= IDLE;
                end
                GRAVA: begin
                    if (k == len) begin
                        gravado     <= 1'b1;
                        pode_gravar <= 1'b0;
                        ocupada     <= 1'b0;
                        estado      <= IDLE;
                        if (jog_r) begin
                            pecas_j1    <= pecas_j1 + CNT_W'(1);
                            completo[1] <= (pecas_j1 + CNT_W'(1) == CNT_W'(MAX_PECAS));
                        end else begin
                            pecas_j0    <= pecas_j0 + CNT_W'(1);
                            completo[0] <= (pecas_j0 + CNT_W'(1) == CNT_W'(MAX_PECAS));
                        end
                    end else begin
                        mapa[jog_r][idx] <= 1'b1;
                        k                <= k + K_W'(1);
                    end
                end
                default: begin
                    ocupada <= 1'b0;
                    estado  <= IDLE;
                end
            endcase
        end
    end

endmodule
